// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state type, counter sizing and configuration legality helpers
package serial_adder_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  localparam int MIN_BITS_PER_CYCLE = 1;
  function automatic int cnt_width(input int steps);
    return steps > 1 ? $clog2(steps) : 1;
  endfunction
  function automatic bit cfg_ok(input int width, input int bpc);
    return width >= 1 && bpc >= MIN_BITS_PER_CYCLE && width % bpc == 0;
  endfunction
endpackage

// File: rtl/serial_adder_fa_cell.sv
// fa_cell: 1-bit full adder (a_i, b_i, ci_i in; s_o sum, co_o carry out)
module fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);
  assign s_o = a_i ^ b_i ^ ci_i;
  assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle chunked a+b+cin adder (clk, rst, in_valid/in_ready/a/b/cin in-side, out_valid/out_ready/sum/cout/ovf out-side)
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int B = BITS_PER_CYCLE;
  localparam int STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int CW = cnt_width(STEPS);
  if (!cfg_ok(WIDTH, BITS_PER_CYCLE)) begin : g_bad
    $error("serial_adder: BITS_PER_CYCLE must divide WIDTH");
  end
  state_e state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d, sum_q, sum_d, s_shift;
  logic c_q, c_d, cout_q, cout_d, ovf_q, ovf_d, last;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [B:0] c;
  logic [B-1:0] chunk;
  assign c[0] = c_q;
  for (genvar i = 0; i < B; i++) begin : g_rip
    fa_cell u_fa (
      .a_i (a_q[i]),
      .b_i (b_q[i]),
      .ci_i(c[i]),
      .s_o (chunk[i]),
      .co_o(c[i+1])
    );
  end
  // chunk enters at the top; after STEPS shifts the LSB chunk sits at bit 0
  assign s_shift = WIDTH'({chunk, s_q} >> B);
  assign last = cnt_q == CW'(STEPS - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: if (in_valid) begin
        a_d     = a;
        b_d     = b;
        c_d     = cin;
        cnt_d   = '0;
        state_d = BUSY;
      end
      BUSY: begin
        a_d   = a_q >> B;
        b_d   = b_q >> B;
        s_d   = s_shift;
        c_d   = c[B];
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          sum_d   = s_shift;
          cout_d  = c[B];
          // on the last chunk its MSB is bit WIDTH-1: carry in vs carry out
          ovf_d   = c[B-1] ^ c[B];
          state_d = DONE;
        end
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign sum = sum_q;
  assign cout = cout_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and random checks of serial_adder across several WIDTH/BITS_PER_CYCLE configurations
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic iv_s[6], ir_s[6], ov_s[6], or_s[6], ci_s[6], co_s[6], vf_s[6];
  logic [15:0] a_s[6], b_s[6], sm_s[6];
  int checks = 0;
  int failures = 0;
  function automatic int wof(input int k);
    return k < 2 ? 8 : 16;
  endfunction
  function automatic int bof(input int k);
    case (k)
      0: return 1;
      1: return 4;
      2: return 1;
      3: return 2;
      4: return 4;
      default: return 16;
    endcase
  endfunction
  for (genvar k = 0; k < 6; k++) begin : g_dut
    localparam int W = wof(k);
    logic [W-1:0] s;
    serial_adder #(.WIDTH(W), .BITS_PER_CYCLE(bof(k))) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (iv_s[k]),
      .in_ready (ir_s[k]),
      .a        (a_s[k][W-1:0]),
      .b        (b_s[k][W-1:0]),
      .cin      (ci_s[k]),
      .out_valid(ov_s[k]),
      .out_ready(or_s[k]),
      .sum      (s),
      .cout     (co_s[k]),
      .ovf      (vf_s[k])
    );
    assign sm_s[k] = 16'(s);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_op(input int k, input logic [15:0] a, input logic [15:0] b, input logic ci,
                       output int lat, output logic [15:0] s, output logic co, output logic vf);
    int n;
    n = 0;
    while (!ir_s[k] && n < 100) begin tick(); n++; end
    a_s[k] = a; b_s[k] = b; ci_s[k] = ci; iv_s[k] = 1'b1;
    tick();
    iv_s[k] = 1'b0;
    lat = 0;
    while (!ov_s[k] && lat < 100) begin tick(); lat++; end
    s = sm_s[k]; co = co_s[k]; vf = vf_s[k];
  endtask
  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    for (int k = 0; k < 6; k++) begin
      checks++;
      if ({ir_s[k], ov_s[k], co_s[k], vf_s[k], sm_s[k]} !== {4'b1000, 16'h0}) begin
        failures++;
        $display("FAIL reset[%0d] ir=%b ov=%b co=%b vf=%b sum=%h want ir=1 ov=0 co=0 vf=0 sum=0",
                 k, ir_s[k], ov_s[k], co_s[k], vf_s[k], sm_s[k]);
      end
    end
    rst = 1'b0;
    tick();
  endtask
  task automatic chk_res(input string nm, input int lat, input logic [15:0] s, input logic co, input logic vf,
                         input int elat, input logic [15:0] es, input logic eco, input logic evf);
    checks++;
    if ({lat, s, co, vf} !== {elat, es, eco, evf}) begin
      failures++;
      $display("FAIL %s lat=%0d sum=%h cout=%b ovf=%b want lat=%0d sum=%h cout=%b ovf=%b",
               nm, lat, s, co, vf, elat, es, eco, evf);
    end
  endtask
  task automatic test_basic();
    int lat; logic [15:0] s; logic co, vf;
    or_s[0] = 1'b1;
    do_op(0, 16'h5A, 16'h3C, 1'b0, lat, s, co, vf);
    chk_res("basic", lat, s, co, vf, 8, 16'h96, 1'b0, 1'b1);
    tick();
    checks++;
    if ({ir_s[0], ov_s[0]} !== 2'b10) begin
      failures++;
      $display("FAIL basic_ready ir=%b ov=%b want ir=1 ov=0", ir_s[0], ov_s[0]);
    end
  endtask
  task automatic test_carry();
    int lat; logic [15:0] s; logic co, vf;
    or_s[0] = 1'b1;
    do_op(0, 16'hFF, 16'h01, 1'b0, lat, s, co, vf);
    chk_res("wrap", lat, s, co, vf, 8, 16'h00, 1'b1, 1'b0);
    do_op(0, 16'h7F, 16'h00, 1'b1, lat, s, co, vf);
    chk_res("cin_ovf", lat, s, co, vf, 8, 16'h80, 1'b0, 1'b1);
    tick();
  endtask
  task automatic test_backpressure();
    int lat; logic [15:0] s; logic co, vf;
    or_s[0] = 1'b0;
    while (!ir_s[0]) tick();
    a_s[0] = 16'h12; b_s[0] = 16'h34; ci_s[0] = 1'b0; iv_s[0] = 1'b1;
    tick();
    a_s[0] = 16'hFF; b_s[0] = 16'hFF; ci_s[0] = 1'b1;
    lat = 0;
    while (!ov_s[0] && lat < 100) begin tick(); lat++; end
    s = sm_s[0]; co = co_s[0]; vf = vf_s[0];
    chk_res("bp_result", lat, s, co, vf, 8, 16'h46, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({ov_s[0], ir_s[0], sm_s[0], co_s[0], vf_s[0]} !== {2'b10, 16'h46, 2'b00}) begin
        failures++;
        $display("FAIL bp_hold[%0d] ov=%b ir=%b sum=%h co=%b vf=%b want ov=1 ir=0 sum=46 co=0 vf=0",
                 i, ov_s[0], ir_s[0], sm_s[0], co_s[0], vf_s[0]);
      end
    end
    or_s[0] = 1'b1; a_s[0] = 16'h01; b_s[0] = 16'h02; ci_s[0] = 1'b0;
    tick();
    checks++;
    if ({ov_s[0], ir_s[0]} !== 2'b01) begin
      failures++;
      $display("FAIL bp_handshake ov=%b ir=%b want ov=0 ir=1", ov_s[0], ir_s[0]);
    end
    tick();
    iv_s[0] = 1'b0;
    checks++;
    if (ir_s[0] !== 1'b0) begin
      failures++;
      $display("FAIL bp_accept_next ir=%b want 0", ir_s[0]);
    end
    lat = 0;
    while (!ov_s[0] && lat < 100) begin tick(); lat++; end
    chk_res("bp_next", lat, sm_s[0], co_s[0], vf_s[0], 8, 16'h03, 1'b0, 1'b0);
    tick();
  endtask
  task automatic test_reset_mid();
    int lat; logic [15:0] s; logic co, vf; logic seen;
    or_s[0] = 1'b1;
    while (!ir_s[0]) tick();
    a_s[0] = 16'h55; b_s[0] = 16'h11; ci_s[0] = 1'b0; iv_s[0] = 1'b1;
    tick();
    iv_s[0] = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({ov_s[0], ir_s[0], sm_s[0]} !== {2'b01, 16'h0}) begin
      failures++;
      $display("FAIL mid_reset ov=%b ir=%b sum=%h want ov=0 ir=1 sum=0", ov_s[0], ir_s[0], sm_s[0]);
    end
    seen = 1'b0;
    repeat (12) begin tick(); if (ov_s[0]) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_no_result saw_valid=%b want 0", seen);
    end
    do_op(0, 16'h10, 16'h20, 1'b0, lat, s, co, vf);
    chk_res("after_reset", lat, s, co, vf, 8, 16'h30, 1'b0, 1'b0);
    tick();
  endtask
  task automatic test_chunked();
    int lat; logic [15:0] s; logic co, vf;
    or_s[1] = 1'b1;
    do_op(1, 16'h9C, 16'h78, 1'b1, lat, s, co, vf);
    chk_res("chunk4", lat, s, co, vf, 2, 16'h15, 1'b1, 1'b0);
    tick();
    or_s[5] = 1'b1;
    do_op(5, 16'h7FFF, 16'h0001, 1'b0, lat, s, co, vf);
    chk_res("single_ovf", lat, s, co, vf, 1, 16'h8000, 1'b0, 1'b1);
    do_op(5, 16'hFFFF, 16'hFFFF, 1'b1, lat, s, co, vf);
    chk_res("single_wrap", lat, s, co, vf, 1, 16'hFFFF, 1'b1, 1'b0);
    tick();
  endtask
  task automatic test_random();
    int lat, n; logic [15:0] s, ra, rb; logic co, vf, rc, rdy, evf; logic [16:0] e;
    for (int k = 2; k < 6; k++) begin
      or_s[k] = 1'b0;
      repeat (250) begin
        ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom_range(0, 1));
        e = {1'b0, ra} + {1'b0, rb} + 17'(rc);
        evf = (ra[15] == rb[15]) && (e[15] != ra[15]);
        do_op(k, ra, rb, rc, lat, s, co, vf);
        chk_res($sformatf("rand[%0d] %h+%h+%b", k, ra, rb, rc), lat, s, co, vf, 16 / bof(k), e[15:0], e[16], evf);
        n = 0;
        do begin
          rdy = ($urandom_range(0, 2) == 0) || n > 20;
          or_s[k] = rdy;
          tick();
          n++;
          if (!rdy && {ov_s[k], sm_s[k], co_s[k], vf_s[k]} !== {1'b1, s, co, vf}) begin
            checks++;
            failures++;
            $display("FAIL rand_hold[%0d] ov=%b sum=%h want ov=1 sum=%h", k, ov_s[k], sm_s[k], s);
          end
        end while (!rdy);
        or_s[k] = 1'b0;
      end
    end
  endtask
  initial begin
    for (int k = 0; k < 6; k++) begin
      iv_s[k] = 1'b0; or_s[k] = 1'b0; ci_s[k] = 1'b0; a_s[k] = '0; b_s[k] = '0;
    end
    test_reset();
    test_basic();
    test_carry();
    test_backpressure();
    test_reset_mid();
    test_chunked();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #5ms;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised multi-cycle adder for WIDTH-bit operands with carry-in.
- Each cycle it adds BITS_PER_CYCLE bits, LSB chunk first, through a ripple of full-adder cells, and carries between cycles in a register.
- Uses valid/ready handshakes on the input and output sides.
- Provides a small-area add/accumulate engine for datapaths where one add per several cycles is acceptable.

Parameters:
- WIDTH, 8: operand and sum width in bits. Must be ≥ 1.
- BITS_PER_CYCLE, 1: bits processed per cycle. Must divide WIDTH; otherwise elaboration fails.
- STEPS, WIDTH/BITS_PER_CYCLE: derived localparam, the number of compute cycles.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  a+b+cin modulo 2^WIDTH.
- cout  out  1  unsigned carry-out.
- ovf  out  1  signed two's-complement overflow.

Behaviour:
- One clock domain. Reset is synchronous and active-high on clk/rst. While rst=1, all other inputs are ignored.
- Reset values:
  - state=IDLE
  - in_ready=1
  - out_valid=0
  - sum=0, cout=0, ovf=0
  - step counter=0, carry register=0
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid=1 at an edge, latch a, b and cin into the operand shift registers and the carry register, clear the counter, and go to BUSY.
- BUSY:
  - in_ready=0, out_valid=0.
  - Each cycle, add the low BITS_PER_CYCLE bits of the A and B shift registers plus the carry register.
  - Shift the chunk sum into the top of the sum shift register; shift A and B right by BITS_PER_CYCLE; update the carry register.
  - Also record the carry into the MSB of the chunk.
  - On the cycle with counter=STEPS-1:
    - load sum=final shift value and cout=final carry;
    - set ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1;
    - go to DONE.
- DONE:
  - out_valid=1, in_ready=0.
  - sum, cout and ovf stay stable while out_ready=0, for any duration.
  - On out_valid&&out_ready, go to IDLE.
- Latency: operands accepted at edge k give out_valid=1 after edge k+STEPS. Minimum issue interval is STEPS+2 cycles.
- sum, cout and ovf are registered outputs. They change only on entry to DONE, or to 0 on reset. Between operations they hold the last result.
- in_ready is 0 in DONE, so a new request offered in the same cycle as the output handshake is not accepted. It is accepted on the next edge, in IDLE.
- in_valid during BUSY or DONE is ignored; the operand registers are not disturbed.
- Reset mid-operation aborts the operation immediately. The next cycle shows the reset values and no result is emitted.
- Width rules:
  - chunk adder is BITS_PER_CYCLE+1 bits;
  - counter is clog2(STEPS) bits, minimum 1;
  - sum wraps modulo 2^WIDTH.
- Degenerate case STEPS=1 (BITS_PER_CYCLE=WIDTH): a single BUSY cycle, latency 1.

Decomposition:
- Shared package serial_adder_pkg:
  - state enum {IDLE, BUSY, DONE};
  - function computing the counter width;
  - constant for the WIDTH/BITS_PER_CYCLE legality check.
- Sub-module fa_cell: 1-bit full adder, sum=a^b^ci, co=a&b | ci&(a^b).
  - Instantiated BITS_PER_CYCLE times in a generate ripple.
  - The carry into the top cell is exported for the ovf calculation.
- Top level holds the FSM, counter, shift registers and output registers.

Test Plan:
- Basic add, WIDTH=8, BITS_PER_CYCLE=1: a=0x5A, b=0x3C, cin=0, out_ready=1 → out_valid rises exactly 8 cycles after accept; sum=0x96, cout=0, ovf=1; in_ready returns to 1 one cycle after the output handshake.
- Carry and wrap: a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, ovf=0. Also a=0x7F, b=0x00, cin=1 → sum=0x80, cout=0, ovf=1.
- Backpressure: out_ready=0 for 5 cycles after out_valid → sum, cout, ovf and out_valid stay constant; in_valid pulses during BUSY and DONE are not accepted; exactly one result is delivered when out_ready=1.
- Reset mid-operation: assert rst at step 3 of an 8-step add → the next cycle shows out_valid=0, in_ready=1, sum=0; no result is produced; a following add of 0x10+0x20 gives 0x30.
- Chunked mode, WIDTH=8, BITS_PER_CYCLE=4: a=0x9C, b=0x78, cin=1 → latency 2 cycles; sum=0x15, cout=1, ovf=0.
- Random regression, WIDTH=16, BITS_PER_CYCLE ∈ {1,2,4,16}, 1000 operations with random out_ready → every result matches the reference model (a+b+cin) including cout and ovf; latency is always STEPS cycles.
